// File: rtl/multi_rpm_meter_pkg.sv
// -----------------------------------------------------------------------------
// multi_rpm_meter_pkg
//   Shared constants and elaboration-time helpers for the multi-channel RPM
//   meter: result width, gate-window length, RPM scale factor and the
//   saturating RPM multiply used when a window closes.
// -----------------------------------------------------------------------------
package multi_rpm_meter_pkg;

    localparam int RPM_W = 32;
    localparam logic [RPM_W-1:0] RPM_MAX = '1;

    // Number of clk cycles in one gate window.
    function automatic int win_cycles(input int clk_period, input int freq);
        return (1_000_000_000 / freq) / clk_period;
    endfunction

    // Edges-per-window to RPM scale factor: 60 s/min * windows/s / pulses/rev.
    function automatic int rpm_const(input int freq, input int ppr);
        return (60 * freq) / ppr;
    endfunction

    // 32x32 multiply into 64 bits (wide enough for any count up to 32 bits),
    // clamped to the 32-bit result range.
    function automatic logic [RPM_W-1:0] sat_mul(input logic [RPM_W-1:0] k,
                                                 input logic [RPM_W-1:0] cnt);
        logic [2*RPM_W-1:0] prod;
        prod = {{RPM_W{1'b0}}, k} * {{RPM_W{1'b0}}, cnt};
        if (prod[2*RPM_W-1:RPM_W] != '0) begin
            return RPM_MAX;
        end
        return prod[RPM_W-1:0];
    endfunction

endpackage

// File: rtl/rpm_edge_channel.sv
// -----------------------------------------------------------------------------
// rpm_edge_channel
//   One encoder channel: 2-flop synchroniser, optional glitch filter, rising
//   edge detector and a saturating per-window edge counter.
//   Optional feature macro: MULTI_RPM_METER_DEBOUNCE_EN (adds the glitch
//   filter; input-to-count latency grows from 3 to 3+DEBOUNCE_CYCLES).
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   en       in   counting enable (synchroniser/filter run regardless)
//   data_in  in   raw asynchronous encoder input
//   win_end  in   terminal cycle of the shared gate window
//   count    out  edges counted so far in the current window
//   sat      out  counter hit its ceiling and dropped an edge this window
// -----------------------------------------------------------------------------
module rpm_edge_channel
    import multi_rpm_meter_pkg::*;
#(
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             win_end,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DEBOUNCE_CYCLES < 1) begin : g_err_debounce
        $error("rpm_edge_channel: DEBOUNCE_CYCLES must be >= 1");
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             level;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

`ifdef MULTI_RPM_METER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            filt_q, filt_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // The filtered level flips only once the synced input has disagreed with
    // it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the run.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    assign rise = level & ~prev_q;

    // NOTE: every always_comb assigns all of its outputs a default first, so
    // no path through the if/else leaves a variable unassigned (no latches).
    always_comb begin
        sync1_d = data_in;
        sync2_d = sync1_q;
        prev_d  = level;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (en) begin
            if (win_end) begin
                // An edge on the closing cycle opens the next window.
                cnt_d = rise ? CNT_W'(1) : '0;
                sat_d = 1'b0;
            end else if (rise) begin
                if (cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign count = cnt_q;
    assign sat   = sat_q;

endmodule

// File: rtl/multi_rpm_meter.sv
// -----------------------------------------------------------------------------
// multi_rpm_meter
//   Measures NUM_CH encoder pulse trains against one shared gate window and
//   publishes RPM per channel at every window end.
//   Optional feature macro: MULTI_RPM_METER_DEBOUNCE_EN (per-channel glitch
//   filter of DEBOUNCE_CYCLES; when undefined DEBOUNCE_CYCLES is unused).
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   measurement enable; window and counters hold while low
//   data       in   [NUM_CH] raw asynchronous encoder inputs
//   rpm        out  [NUM_CH*32] results, channel i at [32*i+31:32*i]
//   rpm_valid  out  one-cycle strobe marking a new result set
//   overflow   out  [NUM_CH] per-channel saturation flag of the last window
// -----------------------------------------------------------------------------
module multi_rpm_meter
    import multi_rpm_meter_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CLK_PERIOD      = 10,
    parameter int PPR             = 4,
    parameter int REG_UPDATE_FREQ = 10,
    parameter int CNT_W           = 24,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       data,
    output logic [NUM_CH*RPM_W-1:0] rpm,
    output logic                    rpm_valid,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int WIN_CYC = win_cycles(CLK_PERIOD, REG_UPDATE_FREQ);
    localparam int RPM_K   = rpm_const(REG_UPDATE_FREQ, PPR);
    localparam int WIN_W   = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
    localparam logic [RPM_W-1:0] RPM_K_V   = RPM_W'(RPM_K);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYC - 1);

    if (WIN_CYC < 2) begin : g_err_win
        $error("multi_rpm_meter: gate window must be at least 2 cycles");
    end
    if (((60 * REG_UPDATE_FREQ) % PPR) != 0) begin : g_err_k
        $error("multi_rpm_meter: 60*REG_UPDATE_FREQ must be a multiple of PPR");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_ch
        $error("multi_rpm_meter: NUM_CH must be 1..16");
    end
    if (CNT_W < 1 || CNT_W > RPM_W) begin : g_err_cnt
        $error("multi_rpm_meter: CNT_W must be 1..32");
    end

    logic [WIN_W-1:0]        win_q, win_d;
    logic [NUM_CH*RPM_W-1:0] rpm_q, rpm_d;
    logic [NUM_CH-1:0]       ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    win_end;
    logic [CNT_W-1:0]        count [NUM_CH];
    logic [NUM_CH-1:0]       sat;

    assign win_end = en && (win_q == WIN_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rpm_edge_channel #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .data_in(data[i]),
            .win_end(win_end),
            .count  (count[i]),
            .sat    (sat[i])
        );
    end

    always_comb begin
        win_d   = win_q;
        rpm_d   = rpm_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (win_end) begin
            win_d   = '0;
            valid_d = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                rpm_d[i*RPM_W +: RPM_W] = sat_mul(RPM_K_V, RPM_W'(count[i]));
                ovf_d[i]                = sat[i];
            end
        end else if (en) begin
            win_d = win_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '0;
            rpm_q   <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            rpm_q   <= rpm_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign rpm       = rpm_q;
    assign rpm_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_multi_rpm_meter.sv
// -----------------------------------------------------------------------------
// tb_multi_rpm_meter
//   Directed windows of encoder pulses; each window's expected result set
//   (rpm, overflow, strobe cycle) is queued when the window is driven and a
//   negedge monitor pops and compares it whenever rpm_valid is seen.
//   WIN_CYC=1000, RPM_K=1_500_000, CNT_W=4 (counter ceiling 15).
// -----------------------------------------------------------------------------
module tb_multi_rpm_meter;

    localparam int NUM_CH   = 4;
    localparam int WIN_CYC  = 1000;
    localparam int ST       = 10;   // offset of the first pulse in a window
    localparam int NV       = 10;

`ifdef MULTI_RPM_METER_DEBOUNCE_EN
    localparam int          BND_OFF    = 993;
    localparam logic [31:0] GLITCH_RPM = 32'd0;
`else
    localparam int          BND_OFF    = 997;
    localparam logic [31:0] GLITCH_RPM = 32'd7_500_000;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic [NUM_CH-1:0]       data;
    logic [NUM_CH*32-1:0]    rpm;
    logic                    rpm_valid;
    logic [NUM_CH-1:0]       overflow;

    always #5 clk = ~clk;

    multi_rpm_meter #(
        .NUM_CH         (NUM_CH),
        .CLK_PERIOD     (10),
        .PPR            (4),
        .REG_UPDATE_FREQ(100_000),
        .CNT_W          (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data     (data),
        .rpm      (rpm),
        .rpm_valid(rpm_valid),
        .overflow (overflow)
    );

    typedef struct packed {
        logic [NUM_CH*32-1:0] rpm;
        logic [NUM_CH-1:0]    ovf;
        logic [31:0]          cyc;
    } exp_t;

    exp_t sb [$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_valid = 0;
    int   pcyc    = 0;
    bit   carry   = 1'b0;
    logic [NUM_CH*32-1:0] last_rpm = '0;
    logic [NUM_CH-1:0]    last_ovf = '0;

    // Per window: pulse count, width and spacing per channel, boundary edge
    // on ch1, en gap (position, length), expected rpm and overflow.
    int v_n  [NV][4] = '{'{10,0,0,0}, '{10,0,0,0}, '{0,3,0,0}, '{0,1,0,0},
                         '{14,0,20,0}, '{0,0,2,0}, '{6,0,0,5}, '{1,2,3,4},
                         '{9,4,0,2},  '{2,0,1,0}};
    int v_w  [NV][4] = '{'{50,10,10,10}, '{50,10,10,10}, '{10,10,10,10},
                         '{10,10,10,10}, '{10,10,10,10}, '{10,10,10,10},
                         '{10,10,10,2},  '{10,10,10,10}, '{10,10,10,10},
                         '{10,10,10,10}};
    int v_sp [NV][4] = '{'{100,100,100,100}, '{100,100,100,100},
                         '{100,100,100,100}, '{100,100,100,100},
                         '{60,100,40,100},   '{100,100,40,100},
                         '{100,100,100,20},  '{100,100,100,100},
                         '{100,100,100,100}, '{100,100,100,100}};
    bit v_bnd     [NV] = '{0,0,1,0,0,0,0,0,0,0};
    int v_gap_at  [NV] = '{0,0,0,0,0,0,0,0,400,0};
    int v_gap_len [NV] = '{0,0,0,0,0,0,0,0,300,300};
    logic [31:0] v_rpm [NV][4] = '{
        '{32'd15_000_000, 32'd0, 32'd0, 32'd0},
        '{32'd15_000_000, 32'd0, 32'd0, 32'd0},
        '{32'd0, 32'd4_500_000, 32'd0, 32'd0},
        '{32'd0, 32'd3_000_000, 32'd0, 32'd0},
        '{32'd21_000_000, 32'd0, 32'd22_500_000, 32'd0},
        '{32'd0, 32'd0, 32'd3_000_000, 32'd0},
        '{32'd9_000_000, 32'd0, 32'd0, GLITCH_RPM},
        '{32'd1_500_000, 32'd3_000_000, 32'd4_500_000, 32'd6_000_000},
        '{32'd13_500_000, 32'd6_000_000, 32'd0, 32'd3_000_000},
        '{32'd3_000_000, 32'd0, 32'd1_500_000, 32'd0}};
    logic [3:0] v_ovf [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, pcyc);
        end
    endtask

    function automatic logic pat(input int n, input int w, input int sp,
                                 input int j);
        if (j < ST) return 1'b0;
        return ((j - ST) / sp < n) && ((j - ST) % sp < w);
    endfunction

    function automatic logic [NUM_CH-1:0] win_data(input int v, input int j);
        logic [NUM_CH-1:0] d;
        for (int c = 0; c < NUM_CH; c++) d[c] = pat(v_n[v][c], v_w[v][c], v_sp[v][c], j);
        if (v_bnd[v] && j >= BND_OFF) d[1] = 1'b1;
        if (carry && j < 5) d[1] = 1'b1;
        return d;
    endfunction

    // en held low; all inputs toggle (must be ignored); outputs must hold.
    task automatic run_gap(input int len);
        for (int g = 0; g < len; g++) begin
            @(negedge clk);
            en   = 1'b0;
            data = (g % 10 < 5) ? 4'hF : 4'h0;
            if (g == len / 2) begin
                check("hold_valid", 64'(rpm_valid), 64'd0);
                for (int c = 0; c < NUM_CH; c++)
                    check($sformatf("hold_rpm[%0d]", c),
                          64'(rpm[c*32 +: 32]), 64'(last_rpm[c*32 +: 32]));
                check("hold_ovf", 64'(overflow), 64'(last_ovf));
            end
        end
    endtask

    task automatic run_window(input int v);
        exp_t e;
        for (int j = 0; j < WIN_CYC; j++) begin
            if (v_gap_len[v] > 0 && j == v_gap_at[v]) run_gap(v_gap_len[v]);
            @(negedge clk);
            en   = 1'b1;
            data = win_data(v, j);
        end
        carry = v_bnd[v];
        for (int c = 0; c < NUM_CH; c++) e.rpm[c*32 +: 32] = v_rpm[v][c];
        e.ovf = v_ovf[v];
        e.cyc = 32'(pcyc + 1);
        sb.push_back(e);
        last_rpm = e.rpm;
        last_ovf = e.ovf;
    endtask

    // Monitor: compare the queued result set whenever the strobe is seen.
    always @(negedge clk) begin
        if (rpm_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_valid++;
                for (int c = 0; c < NUM_CH; c++)
                    check($sformatf("win%0d_rpm[%0d]", n_valid - 1, c),
                          64'(rpm[c*32 +: 32]), 64'(e.rpm[c*32 +: 32]));
                check($sformatf("win%0d_ovf", n_valid - 1), 64'(overflow), 64'(e.ovf));
                check($sformatf("win%0d_cycle", n_valid - 1), 64'(pcyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #300_000;
        $display("FAIL watchdog: time limit reached, %0d strobes seen", n_valid);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        data = '0;
        repeat (5) @(negedge clk);
        check("reset_rpm", 64'(rpm != '0), 64'd0);
        check("reset_ovf", 64'(overflow), 64'd0);
        check("reset_valid", 64'(rpm_valid), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < NV - 1; v++) run_window(v);

        // Reset half-way through a window: partial counts must vanish.
        for (int j = 0; j < 500; j++) begin
            @(negedge clk);
            en   = 1'b1;
            data = win_data(7, j);
        end
        @(negedge clk);
        rst  = 1'b1;
        en   = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        check("midrst_rpm", 64'(rpm != '0), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        check("midrst_valid", 64'(rpm_valid), 64'd0);
        rst      = 1'b0;
        last_rpm = '0;
        last_ovf = '0;
        run_window(NV - 1);

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(sb.size()), 64'd0);
        check("strobe_count", 64'(n_valid), 64'(NV));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_rpm_meter.md
Name: multi_rpm_meter

Overview:
Multi-channel successor to the single-channel tachometer counter. It measures NUM_CH independent encoder pulse trains against one shared gate window. Each channel's raw input is synchronised into the `clk` domain and rising edges are counted. At every window end, RPM is latched per channel and a one-cycle valid strobe is raised. The block sits between the encoder input pins and the register file / status bus.

Parameters:
- NUM_CH, 4: number of independent encoder channels (1..16).
- CLK_PERIOD, 10: `clk` period in ns.
- PPR, 4: encoder pulses per revolution.
- REG_UPDATE_FREQ, 10: result update rate in Hz.
- CNT_W, 24: width of each per-channel edge counter.
- DEBOUNCE_CYCLES, 4: stable cycles required by the optional filter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  measurement enable.
- data  in  NUM_CH  raw asynchronous encoder inputs, one bit per channel.
- rpm  out  NUM_CH*32  packed results; channel i occupies bits [32*i+31 : 32*i].
- rpm_valid  out  1  one-cycle strobe marking a new result set.
- overflow  out  NUM_CH  per-channel saturation flag for the last completed window.

Behaviour:
- Reset values: rpm=0, rpm_valid=0, overflow=0, window counter=0, all edge counters=0, all synchroniser flops=0.
- Derived constants (elaboration time):
  - WIN_CYC = (1_000_000_000/REG_UPDATE_FREQ)/CLK_PERIOD.
  - RPM_K = (60*REG_UPDATE_FREQ)/PPR.
  - Elaboration fails if WIN_CYC<2 or if (60*REG_UPDATE_FREQ) mod PPR != 0.
- Input path, per channel: 2-flop synchroniser, then an edge register. A rising edge is synced==1 && prev==0. An edge on a data pin is counted 3 cycles after the pin toggles.
- Edges are counted only from `clk` logic. No logic is clocked by `data`.
- Window counter: runs 0..WIN_CYC-1 while en=1 and holds while en=0. The terminal cycle is window counter == WIN_CYC-1 with en=1, so the window is exactly WIN_CYC cycles long.
- On the terminal cycle, on the next edge, for every channel simultaneously:
  - rpm[i] is set to RPM_K*count[i], computed at 32+CNT_W bits. If the product exceeds 32'hFFFF_FFFF it saturates to 32'hFFFF_FFFF.
  - overflow[i] is set to the channel's saturation flag.
  - count[i] is cleared, or set to 1 if an edge is detected in that same cycle; that edge belongs to the new window.
  - rpm_valid is 1 for exactly that one cycle.
- Counter saturation: count[i] stops at 2^CNT_W-1 and sets that channel's saturation flag. The flag clears at window end.
- en=0:
  - Edge counters and the window counter hold; edges are ignored.
  - rpm and overflow hold their values; rpm_valid=0.
  - Synchronisers keep running.
- Reset mid-window: partial counts are discarded. The next rpm_valid is a full WIN_CYC cycles after the first cycle with rst=0 and en=1.
- A channel with no edges in a window reports rpm=0.

Optional Feature:
- Macro: MULTI_RPM_METER_DEBOUNCE_EN.
- Defined: a per-channel glitch filter sits between the synchroniser and the edge detector. Its filtered output changes only after the synced input has held a new value for DEBOUNCE_CYCLES consecutive cycles. Input-to-count latency becomes 3+DEBOUNCE_CYCLES cycles. Pulses shorter than DEBOUNCE_CYCLES are rejected.
- Undefined: no filter; latency is 3 cycles; the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package multi_rpm_meter_pkg holds:
  - RPM_W=32;
  - function win_cycles(clk_period, freq);
  - function rpm_const(freq, ppr);
  - function sat_mul returning the saturated 32-bit product.
- Sub-module rpm_edge_channel (synchroniser, optional debounce, edge detect, saturating counter, sat flag) is instanced NUM_CH times in a generate loop. The top holds the shared window counter and the result registers.

Test Plan:
(All scenarios use CLK_PERIOD=10, REG_UPDATE_FREQ=100_000, PPR=4, giving WIN_CYC=1000 and RPM_K=1_500_000.)
- Basic rate: ch0 toggles with a 100-cycle period, other channels idle -> rpm_valid every 1000 cycles; rpm[0]=15_000_000 from the second window on; other channels = 0.
- Boundary edge: ch1 edge detected exactly on the terminal cycle -> not counted in the closing window; the next window's count starts at 1.
- Saturation: CNT_W=4, ch2 sends 20 edges per window -> count stops at 15, overflow[2]=1, rpm[2]=22_500_000; the next window with 2 edges gives overflow[2]=0, rpm[2]=3_000_000.
- Reset and enable: assert rst at cycle 500 of a window -> all outputs 0. Drop en for 300 cycles -> no rpm_valid; the next strobe arrives WIN_CYC enabled cycles after reset release, with counts frozen during en=0.
- Debounce (macro defined, DEBOUNCE_CYCLES=4): 2-cycle glitches on ch3 -> rpm[3]=0; 10-cycle-wide pulses are counted normally.
- Channel independence: NUM_CH=4 with distinct edge rates 1, 2, 3 and 4 per window -> rpm = 1.5M, 3M, 4.5M and 6M, all updated on the same rpm_valid cycle.
